// File: rtl/nrisc_pkg.sv
// nrisc_pkg: shared nRisc constants, opcodes, HALT word and fetch FSM encoding.
package nrisc_pkg;

    localparam int INSTR_WIDTH  = 8;
    localparam int OPCODE_WIDTH = 3;
    localparam int IMM_WIDTH    = 5;

    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = 3'b000;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 3'b001;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = 3'b010;
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = 3'b011;
    localparam logic [OPCODE_WIDTH-1:0] OP_JUMP = 3'b100;
    localparam logic [OPCODE_WIDTH-1:0] OP_SW   = 3'b101;
    localparam logic [OPCODE_WIDTH-1:0] OP_HALT = 3'b110;
    localparam logic [OPCODE_WIDTH-1:0] OP_LI   = 3'b111;

    localparam logic [INSTR_WIDTH-1:0] HALT_INSTR = {OP_HALT, {IMM_WIDTH{1'b0}}};

    localparam logic [1:0] CARGA    = 2'd0;
    localparam logic [1:0] EXECUCAO = 2'd1;
    localparam logic [1:0] PARADO   = 2'd2;

endpackage

// File: rtl/memoria_instrucoes.sv
// memoria_instrucoes: 2**ADDR_WIDTH x 8 instruction array, synchronous write, combinational read.
module memoria_instrucoes
    import nrisc_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   we,
    input  logic [ADDR_WIDTH-1:0]  waddr,
    input  logic [INSTR_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0]  raddr,
    output logic [INSTR_WIDTH-1:0] rdata
);

    logic [INSTR_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/unidade_busca.sv
// unidade_busca: nRisc fetch stage with PC, instruction memory and load/run/halt FSM.
// Optional INSTR_COUNTER_EN adds a saturating 16-bit retired-instruction counter.
module unidade_busca
    import nrisc_pkg::*;
#(
    parameter int                  PC_WIDTH  = 8,
    parameter logic [PC_WIDTH-1:0] BOOT_ADDR = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iniciar,
    input  logic                   prog_we,
    input  logic [PC_WIDTH-1:0]    prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    input  logic                   esc_pc,
    input  logic                   jump,
    input  logic                   beq,
    input  logic                   zero,
    output logic [INSTR_WIDTH-1:0] instrucao,
    output logic [OPCODE_WIDTH-1:0] opcode,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   executando,
    output logic                   parado
`ifdef INSTR_COUNTER_EN
    ,
    output logic [15:0]            contador_instr
`endif
);

    logic [1:0]             estado, estado_n;
    logic [PC_WIDTH-1:0]    pc_n, desvio;
    logic [INSTR_WIDTH-1:0] palavra;

    memoria_instrucoes #(.ADDR_WIDTH(PC_WIDTH)) u_mem (
        .clock (clock),
        .we    (prog_we && estado == CARGA),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc),
        .rdata (palavra)
    );

    assign executando = estado == EXECUCAO;
    assign parado     = estado == PARADO;
    // Outside EXECUCAO the control unit sees HALT so it drops every write enable.
    assign instrucao  = executando ? palavra : HALT_INSTR;
    assign opcode     = instrucao[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign desvio     = PC_WIDTH'($signed(instrucao[IMM_WIDTH-1:0]));

    always_comb begin
        estado_n = estado;
        pc_n     = pc;
        if (estado == CARGA) begin
            pc_n     = BOOT_ADDR;
            estado_n = iniciar ? EXECUCAO : CARGA;
        end else if (executando) begin
            estado_n = esc_pc ? EXECUCAO : PARADO;
            pc_n     = !esc_pc ? pc : (jump || (beq && zero)) ? pc + desvio : pc + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= CARGA;
            pc     <= BOOT_ADDR;
        end else begin
            estado <= estado_n;
            pc     <= pc_n;
        end
    end

`ifdef INSTR_COUNTER_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) contador_instr <= '0;
        else if (executando && esc_pc && contador_instr != 16'hFFFF) contador_instr <= contador_instr + 1'b1;
    end
`endif

endmodule

// File: doc/unidade_busca.md
Name: unidade_busca

Overview:
Instruction-fetch stage of the monocycle nRisc processor, directly upstream of the control unit. It holds the PC and the instruction memory, presents the current instruction and its 3-bit opcode to the control unit, and computes the next PC from the control outputs EscPC, Jump and BEQ plus the ALU zero flag. It also owns the processor run state: program load, run, and halt.

Parameters:
PC_WIDTH, 8, PC and instruction-memory address width; memory depth is 2**PC_WIDTH words.
BOOT_ADDR, 0, PC value after reset and the first instruction executed.

Ports:
clock  input  1  single system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
iniciar  input  1  start pulse; moves CARGA to EXECUCAO.
prog_we  input  1  instruction-memory write enable; honoured only in CARGA.
prog_addr  input  PC_WIDTH  instruction-memory write address.
prog_data  input  8  instruction word to write.
esc_pc  input  1  EscPC from the control unit; 0 means HALT.
jump  input  1  Jump from the control unit.
beq  input  1  BEQ from the control unit.
zero  input  1  ALU zero flag.
instrucao  output  8  current instruction word.
opcode  output  3  instrucao[7:5], fed to the control unit.
pc  output  PC_WIDTH  current PC.
executando  output  1  high in EXECUCAO.
parado  output  1  high in PARADO.

Behaviour:
- Instruction format: [7:5] opcode, [4:0] imm5. Branch and jump offset is sign_extend(imm5) to PC_WIDTH, range -16..+15.
- Reset (reset=0, asynchronous): pc=BOOT_ADDR, state=CARGA, executando=0, parado=0. Memory contents are not cleared. Reset is honoured in any state, including mid-program.
- FSM states:
  - CARGA: pc is held at BOOT_ADDR. On a clock edge with prog_we=1, mem[prog_addr]<=prog_data. If iniciar=1 on the same edge, that write still completes, then the state becomes EXECUCAO.
  - EXECUCAO: instrucao=mem[pc], combinational read with zero fetch latency. At each edge the next PC is chosen in strict priority order:
    1. esc_pc=0: pc is held and the state becomes PARADO.
    2. jump=1: pc<=pc+sext(imm5).
    3. beq=1 and zero=1: pc<=pc+sext(imm5).
    4. Otherwise: pc<=pc+1.
  - PARADO: pc is frozen. iniciar and prog_we are ignored. Only reset leaves this state.
- Arithmetic: all PC arithmetic is modulo 2**PC_WIDTH; wrap-around is silent. With PC_WIDTH=8, 255+1 gives 0 and 3-16 gives 243.
- Offset of 0 is a legal self-loop.
- prog_we is ignored in EXECUCAO and PARADO.
- Outside EXECUCAO, instrucao is forced to 8'b110_00000 (HALT), so the control unit deasserts every write enable. opcode follows instrucao.
- executando=(state==EXECUCAO). parado=(state==PARADO).
- Control inputs are sampled only in EXECUCAO.

Optional Feature:
INSTR_COUNTER_EN
- Defined: adds output contador_instr, 16 bits. It increments on every EXECUCAO edge with esc_pc=1, saturates at 16'hFFFF, resets to 0, and holds in CARGA and PARADO.
- Undefined: neither the port nor the counter logic exists.

Decomposition:
- Shared package nrisc_pkg holds:
  - INSTR_WIDTH=8, OPCODE_WIDTH=3, IMM_WIDTH=5.
  - Opcode constants: OP_ADDI=000, OP_ADD=001, OP_SUBI=010, OP_BEQ=011, OP_JUMP=100, OP_SW=101, OP_HALT=110, OP_LI=111.
  - The HALT instruction word and the FSM state encoding (CARGA, EXECUCAO, PARADO).
- One sub-module: memoria_instrucoes, the 2**PC_WIDTH x 8 array with synchronous write and combinational read. The FSM and PC logic stay in unidade_busca.

Test Plan:
- Reset/load: reset=0, then load mem[0..2]={000_00001,001_00000,110_00000}, then pulse iniciar.
  - During load: pc=0, instrucao=8'hC0, executando=0.
  - After iniciar: pc sequence 0,1,2 with esc_pc driven by the bench model; pc stays at 2 with parado=1.
- Jump backward: pc=5, jump=1, imm5=5'b11101 -> pc=2 next cycle. With pc=3, imm5=-16 -> pc=243.
- Branch: beq=1, imm5=4, pc=10. With zero=0 -> pc=11; with zero=1 -> pc=14. With jump=1 and beq=1 together, the jump path is taken.
- Wrap-around and ignored inputs: pc=255 sequential -> pc=0. A prog_we pulse during EXECUCAO leaves memory unchanged (verified by readback after reset).
- Halt/reset: after HALT, iniciar pulses keep pc frozen and parado=1. Asserting reset asynchronously mid-clock clears parado immediately and sets pc=BOOT_ADDR.
- With INSTR_COUNTER_EN: a 3-instruction program ending in HALT -> contador_instr=2. A preload of 16'hFFFE followed by 3 retirements -> 16'hFFFF.
